// File: rtl/cpu_types_pkg.sv
// Shared bus types for the ccif cache/memory interface.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        D_GAP  = 2'd2,
        I_BUSY = 2'd3
    } arbState;

endpackage

// File: rtl/mem_arbiter.sv
// Grants the single-port RAM to dcache or icache, keeping dcache block pairs intact
// and using a one-bit fairness flag so the icache cannot be starved by flushes.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate
);

    arbState state_q, state_d;
    logic    dcnt_q, dcnt_d;
    logic    favor_q, favor_d;
    logic    dreq;

    assign dreq = dREN | dWEN;

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        favor_d  = favor_q;
        dwait    = 1'b1;
        iwait    = 1'b1;
        dload    = '0;
        iload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                if (favor_q && iREN) begin
                    state_d = I_BUSY;
                end else if (dreq) begin
                    state_d = D_BUSY;
                end else if (iREN) begin
                    state_d = I_BUSY;
                end
            end

            D_BUSY: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!dreq) begin
                    // Request abandoned before the RAM finished: drop the block.
                    state_d = IDLE;
                    dcnt_d  = 1'b0;
                end else if (ramstate == ACCESS) begin
                    dwait = 1'b0;
                    dload = dWEN ? '0 : ramload;
                    if (!dcnt_q) begin
                        dcnt_d  = 1'b1;
                        state_d = D_GAP;
                    end else begin
                        dcnt_d  = 1'b0;
                        favor_d = iREN;
                        state_d = IDLE;
                    end
                end
            end

            D_GAP: begin
                if (dreq) begin
                    state_d = D_BUSY;
                end else begin
                    dcnt_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            I_BUSY: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    favor_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            dcnt_q  <= 1'b0;
            favor_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            favor_q <= favor_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM status and data are driven by hand each cycle.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dREN, dWEN, iREN;
    logic [31:0] daddr, dstore, iaddr, ramload;
    ramstate_t   ramstate;
    logic        dwait, iwait, ramREN, ramWEN;
    logic [31:0] dload, iload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0; dREN = 0; dWEN = 0; iREN = 0;
        daddr = '0; dstore = '0; iaddr = '0; ramload = 32'hFFFF_FFFF; ramstate = FREE;

        // Reset values
        smp();
        chk("rst_dwait", dwait, 1); chk("rst_iwait", iwait, 1);
        chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0); chk("rst_dload", dload, 0);
        chk("rst_iload", iload, 0);
        nxt(); nxt();
        nRST = 1'b1;

        // dcache read block with icache pending throughout
        dREN = 1; daddr = 32'h100; iREN = 1; iaddr = 32'h40; ramstate = FREE;
        smp();
        chk("blk_idle_ren", ramREN, 0); chk("blk_idle_dwait", dwait, 1);
        nxt();
        ramstate = BUSY; ramload = 32'h1111_1111;
        smp();
        chk("blk_w0_ren", ramREN, 1); chk("blk_w0_addr", ramaddr, 32'h100);
        chk("blk_w0_busy_dwait", dwait, 1); chk("blk_w0_busy_dload", dload, 0);
        nxt();
        ramstate = ACCESS; ramload = 32'hAAAA_0100;
        smp();
        chk("blk_w0_dwait", dwait, 0); chk("blk_w0_dload", dload, 32'hAAAA_0100);
        chk("blk_w0_iwait", iwait, 1); chk("blk_w0_iload", iload, 0);
        nxt();
        daddr = 32'h104; ramstate = FREE;
        smp();
        chk("blk_gap_state", dut.state_q, D_GAP);
        chk("blk_gap_ren", ramREN, 0); chk("blk_gap_addr", ramaddr, 0);
        chk("blk_gap_dwait", dwait, 1); chk("blk_gap_iwait", iwait, 1);
        nxt();
        ramstate = BUSY;
        smp();
        chk("blk_w1_addr", ramaddr, 32'h104); chk("blk_w1_ren", ramREN, 1);
        nxt();
        ramstate = ACCESS; ramload = 32'hAAAA_0104;
        smp();
        chk("blk_w1_dwait", dwait, 0); chk("blk_w1_dload", dload, 32'hAAAA_0104);
        chk("blk_w1_iwait", iwait, 1);
        nxt();
        ramstate = FREE;
        smp();
        chk("blk_end_state", dut.state_q, IDLE); chk("blk_end_dcnt", dut.dcnt_q, 0);
        nxt();
        // favor_i set at block end, so the icache wins over the still-pending dREN
        ramstate = ACCESS; ramload = 32'h0000_1234;
        smp();
        chk("fair_addr", ramaddr, 32'h40); chk("fair_ren", ramREN, 1);
        chk("fair_iwait", iwait, 0); chk("fair_iload", iload, 32'h1234);
        chk("fair_dwait", dwait, 1); chk("fair_dload", dload, 0);
        nxt();
        dREN = 0; iREN = 0; ramstate = FREE;
        nxt();

        // Contention: icache and dcache write rise together
        iREN = 1; iaddr = 32'h0; dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        smp();
        chk("con_idle_wen", ramWEN, 0);
        nxt();
        ramstate = ACCESS;
        smp();
        chk("con_w0_wen", ramWEN, 1); chk("con_w0_ren", ramREN, 0);
        chk("con_w0_addr", ramaddr, 32'h200); chk("con_w0_store", ramstore, 32'hDEAD_BEEF);
        chk("con_w0_dwait", dwait, 0); chk("con_w0_dload", dload, 0);
        chk("con_w0_iwait", iwait, 1);
        nxt();
        daddr = 32'h204; dstore = 32'hCAFE_F00D; ramstate = FREE;
        smp();
        chk("con_gap_wen", ramWEN, 0); chk("con_gap_iwait", iwait, 1);
        nxt();
        ramstate = ACCESS;
        smp();
        chk("con_w1_addr", ramaddr, 32'h204); chk("con_w1_store", ramstore, 32'hCAFE_F00D);
        chk("con_w1_dwait", dwait, 0);
        nxt();
        daddr = 32'h300; ramstate = FREE;
        smp();
        chk("con_idle2_state", dut.state_q, IDLE);
        nxt();
        ramstate = BUSY; ramload = 32'h0BAD_0000;
        smp();
        chk("con_i_ren", ramREN, 1); chk("con_i_wen", ramWEN, 0);
        chk("con_i_addr", ramaddr, 32'h0); chk("con_i_busy_iwait", iwait, 1);
        chk("con_i_busy_iload", iload, 0); chk("con_i_dwait", dwait, 1);
        nxt();
        ramstate = ACCESS; ramload = 32'h0000_0600;
        smp();
        chk("con_i_iwait", iwait, 0); chk("con_i_iload", iload, 32'h600);
        nxt();
        iREN = 0; dWEN = 0; ramstate = FREE;
        nxt();

        // Single word write
        dWEN = 1; daddr = 32'h3100; dstore = 32'd5;
        smp();
        nxt();
        ramstate = ACCESS;
        smp();
        chk("one_wen", ramWEN, 1); chk("one_addr", ramaddr, 32'h3100);
        chk("one_store", ramstore, 32'd5); chk("one_dwait", dwait, 0);
        nxt();
        dWEN = 0; ramstate = FREE;
        smp();
        chk("one_gap_state", dut.state_q, D_GAP); chk("one_gap_wen", ramWEN, 0);
        nxt();
        smp();
        chk("one_end_state", dut.state_q, IDLE); chk("one_end_dcnt", dut.dcnt_q, 0);
        nxt();

        // RAM ERROR during an icache read never completes it
        iREN = 1; iaddr = 32'h80;
        smp();
        nxt();
        ramstate = ERROR; ramload = 32'h0EEE_EEEE;
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("err_iwait", iwait, 1); chk("err_iload", iload, 0);
            nxt();
        end
        ramstate = ACCESS; ramload = 32'h5A5A_5A5A;
        smp();
        chk("err_done_iwait", iwait, 0); chk("err_done_iload", iload, 32'h5A5A_5A5A);
        chk("err_done_addr", ramaddr, 32'h80);
        nxt();
        iREN = 0; ramstate = FREE;
        nxt();

        // Both enables: write wins, no read data returned
        dREN = 1; dWEN = 1; daddr = 32'h400; dstore = 32'h77;
        smp();
        nxt();
        ramstate = ACCESS; ramload = 32'hFFFF_0000;
        smp();
        chk("both_wen", ramWEN, 1); chk("both_ren", ramREN, 0);
        chk("both_dload", dload, 0); chk("both_dwait", dwait, 0);
        nxt();
        daddr = 32'h404; ramstate = FREE;
        nxt();
        ramstate = BUSY;
        smp();
        chk("mid_state", dut.state_q, D_BUSY); chk("mid_wen", ramWEN, 1);

        // Asynchronous reset mid-transfer
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_dwait", dwait, 1); chk("arst_wen", ramWEN, 0);
        chk("arst_state", dut.state_q, IDLE); chk("arst_dcnt", dut.dcnt_q, 0);
        dREN = 0; dWEN = 0; ramstate = FREE;
        nxt();
        nRST = 1'b1;
        smp();
        chk("post_rst_state", dut.state_q, IDLE);
        nxt();

        // Fresh request after the aborted block starts a new pair at word 0
        dREN = 1; daddr = 32'h500;
        smp();
        nxt();
        ramstate = ACCESS; ramload = 32'h0000_0500;
        smp();
        chk("new_dload", dload, 32'h500);
        nxt();
        dREN = 0; ramstate = FREE;
        smp();
        chk("new_gap_state", dut.state_q, D_GAP);
        nxt();
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the `ccif` cache bus. It accepts word requests from the dcache (`dREN`/`dWEN`/`daddr`/`dstore`) and the icache (`iREN`/`iaddr`), and grants one of them at a time onto the single-port RAM. It holds a dcache grant across a two-word block transfer, so icache traffic cannot split a block fill or writeback. It also prevents icache starvation with a one-bit fairness flag. It sits between the caches and the RAM model, and it is the only block that drives RAM control.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request.
- `daddr`  in  ADDR_W  dcache word address.
- `dstore`  in  DATA_W  dcache write data.
- `dwait`  out  1  low for exactly the completing cycle of a dcache word.
- `dload`  out  DATA_W  dcache read data, valid while `dwait`=0.
- `iREN`  in  1  icache read request.
- `iaddr`  in  ADDR_W  icache word address.
- `iwait`  out  1  low for exactly the completing cycle of an icache word.
- `iload`  out  DATA_W  icache read data, valid while `iwait`=0.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  ADDR_W  RAM address.
- `ramstore`  out  DATA_W  RAM write data.
- `ramload`  in  DATA_W  RAM read data.
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.

## Operation
- State register holds one of IDLE, D_BUSY, D_GAP, I_BUSY. Also registered: `dcnt` (1 bit, dcache words completed in the current block) and `favor_i` (1 bit).
- A dcache request is `dREN|dWEN`. If both are high, `dWEN` wins: only `ramWEN` is driven, and `dload`=0.
- **IDLE**
  - If `favor_i` && `iREN`, go to I_BUSY.
  - Else if a dcache request is present, go to D_BUSY.
  - Else if `iREN`, go to I_BUSY.
  - All RAM outputs are 0. `dwait`=`iwait`=1.
- **D_BUSY**
  - `ramaddr`=`daddr`, `ramstore`=`dstore`, `ramREN`=`dREN`&~`dWEN`, `ramWEN`=`dWEN`.
  - On `ramstate`==ACCESS: `dwait`=0 and `dload`=`ramload` (dload only when reading).
  - After ACCESS, if `dcnt`==0, set `dcnt`←1 and go to D_GAP. If `dcnt`==1, set `dcnt`←0; set `favor_i`←`iREN`; go to IDLE.
  - If the dcache request drops before ACCESS (abandoned), go to IDLE with `dcnt`←0.
- **D_GAP** (one cycle; lets the dcache present its second word)
  - RAM outputs are 0.
  - If a dcache request is present, go to D_BUSY. Otherwise set `dcnt`←0 and go to IDLE.
- **I_BUSY**
  - `ramaddr`=`iaddr`, `ramREN`=1.
  - On ACCESS: `iwait`=0, `iload`=`ramload`, `favor_i`←0, go to IDLE.
  - If `iREN` drops before ACCESS, go to IDLE.
- RAM status handling:
  - BUSY, FREE and ERROR are all treated as not-done: the wait output stays 1 and the state holds.
  - ERROR never completes a request.
- Ungranted requester: its wait output is 1 and its load output is 0 at all times.

## Timing
- Reset values: state IDLE, `dcnt`=0, `favor_i`=0, `dwait`=`iwait`=1, `dload`=`iload`=0, and all RAM outputs 0.
- Reset asserted mid-transfer aborts the transfer in the same instant. Every output goes to its reset value asynchronously.
- Request latency:
  - A request sampled in IDLE at edge N drives the RAM from cycle N+1.
  - The minimum dcache word takes 2 cycles: IDLE, then D_BUSY with immediate ACCESS.
- Wait/load outputs are combinational from state and `ramstate`. RAM outputs are combinational from state and requester inputs. There is no registered data path.
- Block transfer: the first word takes IDLE→D_BUSY, the gap cycle is D_GAP, and the second word takes D_BUSY. The icache is never granted between the two words of a block.
- A continuous dcache stream (flush) alternates between D_BUSY and D_GAP for a word pair, then passes through IDLE. There, a pending `iREN` with `favor_i` set wins.
- A single dcache word (e.g. the hit-count write) gets no request in D_GAP, so the block returns to IDLE after 1 gap cycle.

## Structure
- `ramstate_t` lives in `cpu_types_pkg`. So do `word_t` and the state enum `arbState`.
- No sub-module is needed. One combinational block computes next-state and outputs, and one `always_ff` holds state, `dcnt` and `favor_i`.

## Test plan
- **Reset:** assert `nRST`=0 while in D_BUSY. Expect `dwait`=1, `ramWEN`=0, and state IDLE after release.
- **dcache read block:** `dREN`, `daddr`=0x100, then 0x104, with RAM ACCESS after 1 BUSY cycle. Expect `dwait` low twice, `dload` = RAM words 0x100 and 0x104, and `ramaddr` never equal to `iaddr` in between.
- **Contention:** `iREN`(0x0) and `dWEN`(0x200, 0xDEADBEEF) rise in the same cycle. Expect the dcache to be granted first and the word written to RAM. After the second dcache word, the icache is granted before any new dcache request.
- **Single word:** `dWEN` to 0x3100 with data 5, then requests drop. Expect one write, D_GAP for 1 cycle, then IDLE.
- **ERROR:** RAM holds ERROR for 10 cycles during an icache read. Expect `iwait`=1 throughout, then completion on the first ACCESS.
- **Both enables:** `dREN`=`dWEN`=1. Expect `ramWEN`=1, `ramREN`=0, and `dload`=0.
